// File: rtl/mic4_cfg_rx.sv
// mic4_cfg_rx: serial configuration receiver that shifts bits in on a synchronized sclk and latches them into a word on lt
module mic4_cfg_rx #(
  parameter int CFG_WIDTH   = 32,
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 sclk_in,
  input  logic                 lt_in,
  input  logic                 sdata_in,
  input  logic                 grst_n_in,
  output logic [CFG_WIDTH-1:0] cfg_word,
  output logic                 cfg_valid,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic                 len_err,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  logic [SYNC_STAGES-1:0] sclk_s, lt_s, sdata_s, grst_s;
  logic sclk_d, lt_d, sclk_e, lt_e, sdata_e, en, grst;
  logic [2:0] hold;
  state_t state, state_nx;
  logic [CFG_WIDTH-1:0] shreg, sh_nx;
  logic [CNT_WIDTH-1:0] cnt_nx;
  assign grst = ~grst_s[SYNC_STAGES-1];
  assign en = hold == 3'(SYNC_STAGES + 1);
  assign busy = state == SHIFT;
  // pin synchronizers, edge detectors registered together with their data bit, and the post-reset hold-off counter
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sclk_s  <= '0;
      lt_s    <= '0;
      sdata_s <= '0;
      grst_s  <= '1;
      sclk_d  <= 1'b0;
      lt_d    <= 1'b0;
      sclk_e  <= 1'b0;
      lt_e    <= 1'b0;
      sdata_e <= 1'b0;
      hold    <= '0;
    end else begin
      sclk_s  <= {sclk_s[SYNC_STAGES-2:0], sclk_in};
      lt_s    <= {lt_s[SYNC_STAGES-2:0], lt_in};
      sdata_s <= {sdata_s[SYNC_STAGES-2:0], sdata_in};
      grst_s  <= {grst_s[SYNC_STAGES-2:0], grst_n_in};
      sclk_d  <= sclk_s[SYNC_STAGES-1];
      lt_d    <= lt_s[SYNC_STAGES-1];
      sclk_e  <= en & sclk_s[SYNC_STAGES-1] & ~sclk_d;
      lt_e    <= en & lt_s[SYNC_STAGES-1] & ~lt_d;
      sdata_e <= sdata_s[SYNC_STAGES-1];
      hold    <= en ? hold : hold + 3'd1;
    end
  end
  // state register; global reset strobe forces IDLE
  always_ff @(posedge clk_in) begin
    state <= (rst || grst) ? IDLE : state_nx;
  end
  // next state plus the shift/count values including a bit arriving this cycle
  always_comb begin
    state_nx = lt_e ? DONE : sclk_e ? SHIFT : (state == DONE) ? IDLE : state;
    sh_nx    = sclk_e ? {shreg[CFG_WIDTH-2:0], sdata_e} : shreg;
    cnt_nx   = (sclk_e && bit_count != '1) ? bit_count + CNT_WIDTH'(1) : bit_count;
  end
  // shift register, counter and latched word; lt clears the frame after capture
  always_ff @(posedge clk_in) begin
    if (rst || grst) begin
      shreg     <= '0;
      bit_count <= '0;
      cfg_word  <= '0;
      cfg_valid <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      cfg_valid <= lt_e;
      if (lt_e) begin
        cfg_word  <= sh_nx;
        len_err   <= cnt_nx != CNT_WIDTH'(CFG_WIDTH);
        shreg     <= '0;
        bit_count <= '0;
      end else begin
        shreg     <= sh_nx;
        bit_count <= cnt_nx;
      end
    end
  end
endmodule

// File: tb/tb_mic4_cfg_rx.sv
// tb_mic4_cfg_rx: table-driven frames with a scoreboard checked on every cfg_valid pulse
module tb_mic4_cfg_rx;
  localparam int S = 2;
  logic clk_in = 0, rst = 1, sclk_in = 0, lt_in = 0, sdata_in = 0, grst_n_in = 1;
  logic [31:0] cfg_word;
  logic cfg_valid, len_err, busy;
  logic [7:0] bit_count;
  typedef struct {int n; logic [63:0] bits; logic [31:0] word; logic err;} vec_t;
  typedef struct {logic [31:0] word; logic err;} exp_t;
  exp_t q[$];
  vec_t v[7];
  int passed = 0, total = 0;

  mic4_cfg_rx #(.CFG_WIDTH(32), .CNT_WIDTH(8), .SYNC_STAGES(S)) dut (
    .clk_in(clk_in), .rst(rst), .sclk_in(sclk_in), .lt_in(lt_in), .sdata_in(sdata_in),
    .grst_n_in(grst_n_in), .cfg_word(cfg_word), .cfg_valid(cfg_valid), .bit_count(bit_count),
    .len_err(len_err), .busy(busy));

  always #2 clk_in = ~clk_in;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
  endtask

  task automatic send_bit(logic b);
    sclk_in = 0; sdata_in = b; #8; sclk_in = 1; #8; sclk_in = 0;
  endtask

  task automatic send_bits(int n, logic [63:0] bits);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic push(logic [31:0] w, logic e);
    exp_t x;
    x.word = w; x.err = e;
    q.push_back(x);
  endtask

  task automatic pulse_lt();
    lt_in = 1; #16; lt_in = 0; #16;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk_in);
    #1;
    chk("pending_frames", q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk_in) begin
    if (cfg_valid) begin
      if (q.size() == 0) chk("unexpected_valid", cfg_valid, 0);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("cfg_word", cfg_word, x.word);
        chk("len_err", len_err, x.err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic b;
    int n;
    v[0] = '{32, 64'hA5C3_0F96, 32'hA5C3_0F96, 1'b0};
    v[1] = '{35, 64'h7_1234_5678, 32'h1234_5678, 1'b1};
    v[2] = '{8, 64'hFF, 32'h0000_00FF, 1'b1};
    v[3] = '{0, 64'h0, 32'h0, 1'b1};
    v[4] = '{32, 64'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    v[5] = '{1, 64'h1, 32'h1, 1'b1};
    v[6] = '{33, 64'h1_0000_0001, 32'h0000_0001, 1'b1};
    repeat (4) @(posedge clk_in);
    #1;
    chk("rst_cfg_word", cfg_word, 0);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    repeat (S + 3) @(posedge clk_in);
    #1;
    for (int k = 0; k < 7; k++) begin
      send_bits(v[k].n, v[k].bits);
      #16;
      chk("frame_bit_count", bit_count, v[k].n);
      if (v[k].n > 0) chk("frame_busy", busy, 1);
      push(v[k].word, v[k].err);
      pulse_lt();
      drain();
      chk("post_bit_count", bit_count, 0);
      chk("post_busy", busy, 0);
    end
    w = 0;
    for (int i = 0; i < 260; i++) begin
      b = (i % 3) == 0;
      send_bit(b);
      w = {w[30:0], b};
    end
    #16;
    chk("sat_bit_count", bit_count, 255);
    push(w, 1);
    pulse_lt();
    drain();
    send_bits(20, 64'hABCDE);
    grst_n_in = 0; #20; grst_n_in = 1; #24;
    chk("grst_bit_count", bit_count, 0);
    chk("grst_cfg_word", cfg_word, 0);
    chk("grst_len_err", len_err, 0);
    send_bits(32, 64'h0000_FFFF);
    push(32'h0000_FFFF, 0);
    pulse_lt();
    drain();
    send_bits(10, 64'h2AA);
    #8; rst = 1; #8; rst = 0; #24;
    chk("midrst_bit_count", bit_count, 0);
    push(32'h0, 1);
    pulse_lt();
    drain();
    sclk_in = 1; lt_in = 1; rst = 1; #8; rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      chk("hold_valid", cfg_valid, 0);
      chk("hold_bit_count", bit_count, 0);
    end
    sclk_in = 0; lt_in = 0; #16;
    w = 32'h89AB_CDEF;
    send_bits(31, {33'b0, w[31:1]});
    sclk_in = 0; sdata_in = w[0];
    push(w, 0);
    #8;
    sclk_in = 1; lt_in = 1;
    n = 0;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      @(posedge clk_in); #1;
      if (cfg_valid) n = i;
    end
    chk("lt_latency", n, S + 2);
    sclk_in = 0; lt_in = 0;
    drain();
    chk("final_bit_count", bit_count, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
